// File: rtl/player_action_if.sv
// Controller pin bundle and action outputs for one player.
// The bench (master) drives the pins; the sequencer (slave) drives the action outputs.
interface player_action_if;
    logic       left_l;
    logic       right_l;
    logic       up_l;
    logic       down_l;
    logic       attack;
    logic       pery;
    logic [2:0] action;
    logic       facing_right;
    logic       strike;
    logic       busy;
    logic [5:0] btn_state;

    modport master (
        output left_l, right_l, up_l, down_l, attack, pery,
        input  action, facing_right, strike, busy, btn_state
    );

    modport slave (
        input  left_l, right_l, up_l, down_l, attack, pery,
        output action, facing_right, strike, busy, btn_state
    );
endinterface

// File: rtl/player_action_fsm.sv
// Per-player input sequencer: synchronizes and debounces the six controller inputs,
// then runs the walk/crouch/jump/attack/cooldown/parry move state machine.
module player_action_fsm #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] JUMP_CYCLES     = 24'd5000000,
    parameter logic [23:0] ATTACK_CYCLES   = 24'd2500000,
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd2500000
) (
    input  logic             clk,
    input  logic             reset,
    player_action_if.slave   pif
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WALK_L   = 3'd1,
        WALK_R   = 3'd2,
        CROUCH   = 3'd3,
        JUMP     = 3'd4,
        ATTACK   = 3'd5,
        COOLDOWN = 3'd6,
        PARRY    = 3'd7
    } state_t;

    // Raw pin order matches btn_state; ones mark the active-low pins.
    localparam logic [5:0] IDLE_LEVEL = 6'b001111;

    logic [5:0]  raw;
    logic [5:0]  synced;
    logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [5:0]  btn_q, btn_d;
    logic [15:0] cnt_q [6];
    logic [15:0] cnt_d [6];
    logic        atk_prev_q, atk_prev_d;
    logic        atk_rise;
    state_t      state_q, state_d, free_next;
    logic [23:0] timer_q, timer_d;
    logic        facing_q, facing_d;
    logic        timed;

    assign raw    = {pif.pery, pif.attack, pif.down_l, pif.up_l, pif.right_l, pif.left_l};
    assign synced = sync2_q ^ IDLE_LEVEL;

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        btn_d      = btn_q;
        atk_prev_d = btn_q[4];
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != btn_q[i]) begin
                if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    btn_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign atk_rise = btn_q[4] & ~atk_prev_q;
    assign timed    = (state_q == JUMP) || (state_q == ATTACK) || (state_q == COOLDOWN);

    always_comb begin
        free_next = IDLE;
        if (atk_rise)                  free_next = ATTACK;
        else if (btn_q[5])             free_next = PARRY;
        else if (btn_q[2])             free_next = JUMP;
        else if (btn_q[3])             free_next = CROUCH;
        else if (btn_q[0] && !btn_q[1]) free_next = WALK_L;
        else if (btn_q[1] && !btn_q[0]) free_next = WALK_R;
    end

    always_comb begin
        state_d  = state_q;
        facing_d = facing_q;
        timer_d  = '0;
        case (state_q)
            IDLE, WALK_L, WALK_R, CROUCH: state_d = free_next;
            PARRY: begin
                if (atk_rise)       state_d = ATTACK;
                else if (!btn_q[5]) state_d = IDLE;
            end
            JUMP:     if (timer_q == JUMP_CYCLES - 24'd1)     state_d = IDLE;
            ATTACK:   if (timer_q == ATTACK_CYCLES - 24'd1)   state_d = COOLDOWN;
            COOLDOWN: if (timer_q == COOLDOWN_CYCLES - 24'd1) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Timer counts cycles spent in the current timed state and restarts on every entry.
        if (timed && (state_d == state_q)) timer_d = timer_q + 24'd1;
        if (state_d == WALK_R)      facing_d = 1'b1;
        else if (state_d == WALK_L) facing_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= IDLE_LEVEL;
            sync2_q    <= IDLE_LEVEL;
            btn_q      <= '0;
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
            atk_prev_q <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            facing_q   <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_q      <= btn_d;
            for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
            atk_prev_q <= atk_prev_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            facing_q   <= facing_d;
        end
    end

    assign pif.action       = state_q;
    assign pif.facing_right = facing_q;
    assign pif.strike       = (state_q == ATTACK) && (timer_q == 24'd0);
    assign pif.busy         = timed;
    assign pif.btn_state    = btn_q;
endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_player_action_fsm;
    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    player_action_if pif ();

    player_action_fsm #(
        .DEBOUNCE_CYCLES(16'd4),
        .JUMP_CYCLES    (24'd10),
        .ATTACK_CYCLES  (24'd6),
        .COOLDOWN_CYCLES(24'd5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pif  (pif)
    );

    typedef struct {
        int         at;
        logic [2:0] act;
        logic       fr;
        logic       stk;
        logic       bsy;
        logic [5:0] btn;
        string      name;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got time %0t, required < 100000", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: compare every expectation tagged with the current cycle; stale ones are misses.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_cmp++;
                if ({pif.action, pif.facing_right, pif.strike, pif.busy, pif.btn_state} !==
                    {sb[i].act, sb[i].fr, sb[i].stk, sb[i].bsy, sb[i].btn}) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got act=%0d fr=%b stk=%b busy=%b btn=%b, required act=%0d fr=%b stk=%b busy=%b btn=%b",
                             sb[i].name, cyc, pif.action, pif.facing_right, pif.strike, pif.busy, pif.btn_state,
                             sb[i].act, sb[i].fr, sb[i].stk, sb[i].bsy, sb[i].btn);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d never checked, now cyc %0d", sb[i].name, sb[i].at, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_pins(input logic l, r, u, d, a, p);
        pif.left_l  = ~l;
        pif.right_l = ~r;
        pif.up_l    = ~u;
        pif.down_l  = ~d;
        pif.attack  = a;
        pif.pery    = p;
    endtask

    task automatic expect_at(input int at, input logic [2:0] act, input logic fr, input logic stk,
                             input logic bsy, input logic [5:0] btn, input string name);
        exp_t e;
        e.at = at; e.act = act; e.fr = fr; e.stk = stk; e.bsy = bsy; e.btn = btn; e.name = name;
        sb.push_back(e);
    endtask

    int t;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        set_pins(0, 0, 0, 0, 0, 0);
        step(2);
        expect_at(cyc, 3'd0, 1, 0, 0, 6'b000000, "reset_state");
        step(1);
        reset = 1'b0;

        // Three-cycle glitch on left never passes the debouncer.
        t = cyc;
        set_pins(1, 0, 0, 0, 0, 0);
        expect_at(t + 6, 3'd0, 1, 0, 0, 6'b000000, "glitch_a");
        expect_at(t + 8, 3'd0, 1, 0, 0, 6'b000000, "glitch_b");
        step(3);
        set_pins(0, 0, 0, 0, 0, 0);
        step(6);

        // Held left: btn after 6 cycles, WALK_L one cycle later.
        t = cyc;
        set_pins(1, 0, 0, 0, 0, 0);
        expect_at(t + 5, 3'd0, 1, 0, 0, 6'b000000, "deb_not_yet");
        expect_at(t + 6, 3'd0, 1, 0, 0, 6'b000001, "deb_left");
        expect_at(t + 7, 3'd1, 0, 0, 0, 6'b000001, "walk_l");
        step(8);
        set_pins(0, 0, 0, 0, 0, 0);
        t = cyc;
        expect_at(t + 6, 3'd1, 0, 0, 0, 6'b000000, "left_rel_btn");
        expect_at(t + 7, 3'd0, 0, 0, 0, 6'b000000, "left_rel_idle");
        step(8);

        // Jump lockout with right held through the jump.
        t = cyc;
        set_pins(0, 0, 1, 0, 0, 0);
        expect_at(t + 6,  3'd0, 0, 0, 0, 6'b000100, "jump_btn");
        expect_at(t + 7,  3'd4, 0, 0, 1, 6'b000100, "jump_enter");
        expect_at(t + 16, 3'd4, 0, 0, 1, 6'b000010, "jump_last");
        expect_at(t + 17, 3'd0, 0, 0, 0, 6'b000010, "jump_exit");
        expect_at(t + 18, 3'd2, 1, 0, 0, 6'b000010, "walk_r_after_jump");
        step(5);
        set_pins(0, 1, 0, 0, 0, 0);
        step(14);
        set_pins(0, 0, 0, 0, 0, 0);
        t = cyc;
        expect_at(t + 7, 3'd0, 1, 0, 0, 6'b000000, "right_rel");
        step(8);

        // Attack chain with the button held throughout.
        t = cyc;
        set_pins(0, 0, 0, 0, 1, 0);
        expect_at(t + 6,  3'd0, 1, 0, 0, 6'b010000, "atk_btn");
        expect_at(t + 7,  3'd5, 1, 1, 1, 6'b010000, "atk_strike");
        expect_at(t + 8,  3'd5, 1, 0, 1, 6'b010000, "atk_strike_off");
        expect_at(t + 12, 3'd5, 1, 0, 1, 6'b010000, "atk_last");
        expect_at(t + 13, 3'd6, 1, 0, 1, 6'b010000, "cool_first");
        expect_at(t + 17, 3'd6, 1, 0, 1, 6'b010000, "cool_last");
        expect_at(t + 18, 3'd0, 1, 0, 0, 6'b010000, "cool_exit");
        expect_at(t + 20, 3'd0, 1, 0, 0, 6'b010000, "held_no_retrigger");
        step(21);
        set_pins(0, 0, 0, 0, 0, 0);
        step(8);

        // Attack edge beats up in the same debounced cycle.
        t = cyc;
        set_pins(0, 0, 1, 0, 1, 0);
        expect_at(t + 7,  3'd5, 1, 1, 1, 6'b010100, "prio_atk_over_up");
        expect_at(t + 18, 3'd0, 1, 0, 0, 6'b000000, "prio_exit");
        expect_at(t + 19, 3'd0, 1, 0, 0, 6'b000000, "prio_idle_stays");
        step(5);
        set_pins(0, 0, 0, 0, 0, 0);
        step(16);

        // Left and right together stay IDLE.
        t = cyc;
        set_pins(1, 1, 0, 0, 0, 0);
        expect_at(t + 7,  3'd0, 1, 0, 0, 6'b000011, "both_lr_a");
        expect_at(t + 10, 3'd0, 1, 0, 0, 6'b000011, "both_lr_b");
        step(11);
        set_pins(0, 0, 0, 0, 0, 0);
        step(8);

        // Parry, attack out of parry, parry release during the attack.
        t = cyc;
        set_pins(0, 0, 0, 0, 0, 1);
        expect_at(t + 7,  3'd7, 1, 0, 0, 6'b100000, "parry_enter");
        expect_at(t + 15, 3'd7, 1, 0, 0, 6'b110000, "parry_atk_btn");
        expect_at(t + 16, 3'd5, 1, 1, 1, 6'b110000, "parry_strike");
        expect_at(t + 21, 3'd5, 1, 0, 1, 6'b110000, "parry_atk_last");
        expect_at(t + 22, 3'd6, 1, 0, 1, 6'b110000, "parry_cool_first");
        expect_at(t + 23, 3'd6, 1, 0, 1, 6'b010000, "parry_rel_ignored");
        expect_at(t + 26, 3'd6, 1, 0, 1, 6'b010000, "parry_cool_last");
        expect_at(t + 27, 3'd0, 1, 0, 0, 6'b010000, "parry_seq_exit");
        step(9);
        set_pins(0, 0, 0, 0, 1, 1);
        step(8);
        set_pins(0, 0, 0, 0, 1, 0);
        step(11);
        set_pins(0, 0, 0, 0, 0, 0);
        step(8);

        // Face left so the reset check has a non-default facing to clear.
        t = cyc;
        set_pins(1, 0, 0, 0, 0, 0);
        expect_at(t + 7, 3'd1, 0, 0, 0, 6'b000001, "walk_l_again");
        step(8);
        set_pins(0, 0, 0, 0, 0, 0);
        step(8);

        // Reset during the fourth jump cycle.
        t = cyc;
        set_pins(0, 0, 1, 0, 0, 0);
        expect_at(t + 7,  3'd4, 0, 0, 1, 6'b000100, "rst_jump_enter");
        expect_at(t + 10, 3'd4, 0, 0, 1, 6'b000100, "rst_jump_cyc4");
        expect_at(t + 11, 3'd0, 1, 0, 0, 6'b000000, "rst_mid_jump");
        expect_at(t + 12, 3'd0, 1, 0, 0, 6'b000000, "rst_after_1");
        expect_at(t + 17, 3'd0, 1, 0, 0, 6'b000000, "rst_after_6");
        step(5);
        set_pins(0, 0, 0, 0, 0, 0);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(8);

        step(2);
        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cyc %0d left unchecked at end, now cyc %0d", sb[i].name, sb[i].at, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
